// File: rtl/cpu_arb_pkg.sv
// Shared types for the fetch/data memory-port arbiter: FSM states and grant encodings.
package cpu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERV_I = 2'd1,
        SERV_D = 2'd2
    } arb_state_e;

    typedef logic [1:0] gnt_t;

    localparam gnt_t GNT_NONE = 2'd0;
    localparam gnt_t GNT_I    = 2'd1;
    localparam gnt_t GNT_D    = 2'd2;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Fetch anti-starvation counter: forces a fetch grant after STARVE_MAX data grants.
// Only built when ARB_ANTI_STARVE_EN is defined.
`ifdef ARB_ANTI_STARVE_EN
module mem_arb_starve_ctr
    import cpu_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic idle_i,
    input  logic if_req_i,
    input  gnt_t gnt_i,
    output logic force_i_o
);

    localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (idle_i && !if_req_i) begin
            cnt_d = '0;
        end else if (gnt_i == GNT_I) begin
            cnt_d = '0;
        end else if (gnt_i == GNT_D && if_req_i && cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_i_o = if_req_i && (cnt_q == CntMax);

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between fetch and data stages; data wins by default.
// Define ARB_ANTI_STARVE_EN to enable the fetch anti-starvation counter.
module mem_port_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_done,
    output logic                mem_valid,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                busy
);

    localparam int unsigned BeW = DATA_W / 8;

    // A zero threshold would hand every arbitration to a waiting fetch.
    if (STARVE_MAX == 0) begin : g_bad_starve_max
        $error("STARVE_MAX must be at least 1");
    end

    arb_state_e        state_q, state_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BeW-1:0]    mem_be_q, mem_be_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic if_elig, dm_elig, force_fetch;
    gnt_t gnt;

    // A requester whose done pulse is high has not had a chance to drop its request yet.
    assign if_elig = if_req && !if_done_q;
    assign dm_elig = dm_req && !dm_done_q;

`ifdef ARB_ANTI_STARVE_EN
    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk_i     (clk),
        .clr_i     (clr),
        .idle_i    (state_q == IDLE),
        .if_req_i  (if_req),
        .gnt_i     (gnt),
        .force_i_o (force_fetch)
    );
`else
    assign force_fetch = 1'b0;
`endif

    always_comb begin
        gnt = GNT_NONE;
        if (state_q == IDLE) begin
            if (if_elig && force_fetch) begin
                gnt = GNT_I;
            end else if (dm_elig) begin
                gnt = GNT_D;
            end else if (if_elig) begin
                gnt = GNT_I;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        unique case (state_q)
            IDLE: begin
                case (gnt)
                    GNT_I: begin
                        state_d     = SERV_I;
                        mem_valid_d = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = '0;
                    end
                    GNT_D: begin
                        state_d     = SERV_D;
                        mem_valid_d = 1'b1;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        mem_be_d    = dm_be;
                    end
                    default: ;
                endcase
            end
            SERV_I: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    if_done_d   = 1'b1;
                    if_rdata_d  = mem_rdata;
                end
            end
            SERV_D: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    dm_done_d   = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall_if  = if_req && !if_done_q;
    assign stall_mem = dm_req && !dm_done_q;
    assign busy      = (state_q != IDLE);

endmodule
